// File: rtl/pc_next_unit.sv
// Program-counter stage: PC register, next-PC select, sticky halt and misalignment flags.
// Define PC_RETIRE_CNT_EN to add the retired-instruction counter output retired_cnt.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              PCWre,
    input  logic [1:0]        PCSrc,
    input  logic [ADDR_W-1:0] imm_ext,
    input  logic [25:0]       jaddr,
    output logic [ADDR_W-1:0] pc,
`ifdef PC_RETIRE_CNT_EN
    output logic [31:0]       retired_cnt,
`endif
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              halted,
    output logic              misalign_err
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] next_pc;
    logic              advance;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + (imm_ext << 2);
    assign jump_target   = {pc_plus4[31:28], jaddr, 2'b00};
    assign advance       = (state_q == RUN) && PCWre;

    // Reserved select 2'b11 falls back to sequential fetch without flagging anything.
    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            SRC_SEQ:    next_pc = pc_plus4;
            SRC_BRANCH: next_pc = branch_target;
            SRC_JUMP:   next_pc = jump_target;
            default:    next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (state_q == RUN) begin
            if (PCWre) begin
                pc_d = next_pc;
                if (next_pc[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                end
            end else begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PC_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (advance) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_cnt = retired_q;
`else
    logic unused_advance;
    assign unused_advance = advance;
`endif

    assign pc           = pc_q;
    assign halted       = (state_q == HALT);
    assign misalign_err = misalign_q;

endmodule
